fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, equal to PC.
REQ-006 SHALL have port imem_ready  input  1  memory has returned imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port IR  output  32  held instruction for the decode stage.
REQ-009 SHALL have port IR_valid  output  1  IR holds an unconsumed instruction.
REQ-010 SHALL have port ir_ack  input  1  decode/execute consumes IR this cycle.
REQ-011 SHALL have port Jump  input  1  held IR is J/JAL; redirect to absolute target.
REQ-012 SHALL have port branch_taken  input  1  held IR is a branch whose condition evaluated true.
REQ-013 SHALL have port PC_plus4  output  32  PC of the held IR plus 4 (link value).
REQ-014 SHALL have port instr_count  output  32  count of consumed instructions.

Function
REQ-015 SHALL implement FSM states FETCH and HOLD; reset enters FETCH.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL stay stable at PC until imem_ready.
REQ-017 In FETCH with imem_ready=1, IR SHALL load imem_rdata, IR_valid SHALL be 1 from the next cycle, and the FSM SHALL go to HOLD.
REQ-018 In HOLD, imem_req SHALL be 0, IR and PC SHALL hold, and IR_valid SHALL be 1.
REQ-019 In HOLD with ir_ack=1, PC SHALL load next-PC, IR_valid SHALL drop next cycle, the FSM SHALL return to FETCH, and instr_count SHALL increment by 1.
REQ-020 Next-PC SHALL be: Jump=1 -> {PC_plus4[31:28], IR[25:0], 2'b00}; else branch_taken=1 -> PC_plus4 + (sign-extended IR[15:0] << 2); else PC_plus4.
REQ-021 Jump SHALL take priority when Jump and branch_taken are both 1.
REQ-022 Jump and branch_taken SHALL be sampled only on the ir_ack cycle and ignored otherwise.
REQ-023 ir_ack while IR_valid=0 SHALL be ignored, with no PC or count change.
REQ-024 imem_ready while imem_req=0 SHALL be ignored.
REQ-025 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 0; instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 PC_plus4 SHALL be combinational PC + 4.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles: ack in cycle N, request in cycle N+1, IR_valid in N+2 with zero-wait memory.

Reset
REQ-028 rst=1 SHALL force, asynchronously: PC=RESET_PC, IR=0, IR_valid=0, instr_count=0, state=FETCH.
REQ-029 While rst=1, imem_req SHALL be 0; it SHALL rise on the first clk edge after rst deasserts.
REQ-030 Reset mid-fetch SHALL discard the outstanding request; a late imem_ready SHALL NOT load IR.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, RESET_PC default, and the J/branch field positions (IR[25:0], IR[15:0]).
REQ-032 Next-PC selection SHALL be one combinational sub-module, npc_gen (inputs PC, IR, Jump, branch_taken; output next PC).

Verification
REQ-033 Reset release with memory ready immediately -> imem_addr=0x0, then IR_valid, then ack -> imem_addr=0x4; instr_count=1.
REQ-034 HOLD at PC=0x100, IR=0x1000FFFF, branch_taken=1, ack -> next imem_addr=0x100.
REQ-035 PC=0x0040_0010, IR=0x0810_0000, Jump=1 and branch_taken=1, ack -> next imem_addr=0x0040_0000.
REQ-036 imem_ready held low 5 cycles -> imem_req stays 1 and imem_addr stays constant; IR_valid stays 0 until ready.
REQ-037 PC=0xFFFF_FFFC, ack with no redirect -> next imem_addr=0x0; ir_ack pulse while IR_valid=0 -> instr_count unchanged.
REQ-038 rst asserted mid-FETCH, then imem_ready=1 -> IR stays 0, IR_valid stays 0, imem_addr returns to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state type, reset PC default and
// the instruction fields used to form jump and branch targets.
package fetch_unit_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // J-type target lives in IR[25:0], branch immediate in IR[15:0]
    localparam int J_TARGET_MSB = 25;
    localparam int J_TARGET_LSB = 0;
    localparam int BR_IMM_MSB   = 15;
    localparam int BR_IMM_LSB   = 0;
    localparam int BR_IMM_W     = BR_IMM_MSB - BR_IMM_LSB + 1;

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] ir);
        return {pc_plus4[31:28], ir[J_TARGET_MSB:J_TARGET_LSB], 2'b00};
    endfunction

    function automatic logic [31:0] branch_offset(input logic [31:0] ir);
        return {{(30 - BR_IMM_W){ir[BR_IMM_MSB]}}, ir[BR_IMM_MSB:BR_IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/npc_gen.sv
// Next-PC selection for the held instruction: jump beats branch beats sequential.
module npc_gen
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target(pc_plus4, ir);
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(ir);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: request a word at PC, hold it in IR until the
// decode stage acknowledges it, then advance PC to the selected successor.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic        IR_valid,
    input  logic        ir_ack,
    input  logic        Jump,
    input  logic        branch_taken,
    output logic [31:0] PC_plus4,
    output logic [31:0] instr_count
);

    fetch_state_t state_reg;
    logic         req_en_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  ir_reg;
    logic         ir_valid_reg;
    logic [31:0]  count_reg;
    logic [31:0]  npc;
    logic         fetch_done;
    logic         consume;

    // req_en_reg keeps the request low until the first edge after reset release
    assign imem_req    = (state_reg == FETCH) && req_en_reg;
    assign imem_addr   = pc_reg;
    assign IR          = ir_reg;
    assign IR_valid    = ir_valid_reg;
    assign PC_plus4    = pc_reg + 32'd4;
    assign instr_count = count_reg;

    assign fetch_done = imem_req && imem_ready;
    assign consume    = (state_reg == HOLD) && ir_valid_reg && ir_ack;

    npc_gen u_npc_gen (
        .pc           (pc_reg),
        .ir           (ir_reg),
        .jump         (Jump),
        .branch_taken (branch_taken),
        .next_pc      (npc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            req_en_reg   <= 1'b0;
            pc_reg       <= RESET_PC;
            ir_reg       <= 32'h0;
            ir_valid_reg <= 1'b0;
            count_reg    <= 32'h0;
        end else begin
            req_en_reg <= 1'b1;
            if (fetch_done) begin
                ir_reg       <= imem_rdata;
                ir_valid_reg <= 1'b1;
                state_reg    <= HOLD;
            end else if (consume) begin
                pc_reg       <= npc;
                ir_valid_reg <= 1'b0;
                state_reg    <= FETCH;
                count_reg    <= count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected architectural state is tracked per
// transaction and compared against the DUT on every falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IR;
    logic        IR_valid;
    logic        ir_ack = 1'b0;
    logic        Jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] PC_plus4;
    logic [31:0] instr_count;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .IR           (IR),
        .IR_valid     (IR_valid),
        .ir_ack       (ir_ack),
        .Jump         (Jump),
        .branch_taken (branch_taken),
        .PC_plus4     (PC_plus4),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // expected architectural state
    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_ir    = 32'h0;
    logic        exp_valid = 1'b0;
    logic        exp_req   = 1'b0;
    logic [31:0] exp_count = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // successor address computed arithmetically from the instruction rules
    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ir,
                                              input logic j, input logic b);
        logic [31:0] p4;
        logic [15:0] imm;
        int          off;
        p4 = pc + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
        if (b) begin
            imm = ir[15:0];
            off = int'($signed(imm)) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    always @(negedge clk) begin
        check("imem_req",    {31'h0, imem_req}, {31'h0, exp_req});
        check("imem_addr",   imem_addr,   exp_pc);
        check("IR",          IR,          exp_ir);
        check("IR_valid",    {31'h0, IR_valid}, {31'h0, exp_valid});
        check("PC_plus4",    PC_plus4,    exp_pc + 32'd4);
        check("instr_count", instr_count, exp_count);
    end

    task automatic set_reset_expect();
        exp_pc    = 32'h0;
        exp_ir    = 32'h0;
        exp_valid = 1'b0;
        exp_req   = 1'b0;
        exp_count = 32'h0;
    endtask

    // memory returns w after 'waits' not-ready cycles; stray drives ack/Jump while IR is empty
    task automatic fetch(input logic [31:0] w, input int waits, input logic stray);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            ir_ack     = stray;
            Jump       = stray;
            @(posedge clk); #1;
            ir_ack = 1'b0;
            Jump   = 1'b0;
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        exp_ir    = w;
        exp_valid = 1'b1;
        exp_req   = 1'b0;
        $display("[TB] fetch pc=%08h ir=%08h waits=%0d", exp_pc, w, waits);
    endtask

    task automatic ack(input logic j, input logic b);
        logic [31:0] old_pc;
        old_pc       = exp_pc;
        ir_ack       = 1'b1;
        Jump         = j;
        branch_taken = b;
        @(posedge clk); #1;
        ir_ack       = 1'b0;
        Jump         = 1'b0;
        branch_taken = 1'b0;
        exp_pc    = model_npc(old_pc, exp_ir, j, b);
        exp_valid = 1'b0;
        exp_req   = 1'b1;
        exp_count = exp_count + 32'd1;
        $display("[TB] ack pc=%08h j=%0b b=%0b next=%08h", old_pc, j, b, exp_pc);
    endtask

    // stray memory responses and redirect flags while holding, without ack
    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ready   = 1'b1;
            imem_rdata   = $urandom;
            Jump         = 1'b1;
            branch_taken = 1'b1;
            @(posedge clk); #1;
            imem_ready   = 1'b0;
            Jump         = 1'b0;
            branch_taken = 1'b0;
        end
        $display("[TB] hold idle %0d cycles", n);
    endtask

    initial begin
        set_reset_expect();
        // model self-pins against hand-computed successors
        check("model_branch_back", model_npc(32'h0000_0100, 32'h1000_FFFF, 1'b0, 1'b1), 32'h0000_0100);
        check("model_jump_prio",   model_npc(32'h0040_0010, 32'h0810_0000, 1'b1, 1'b1), 32'h0040_0000);
        check("model_wrap",        model_npc(32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0), 32'h0000_0000);

        // reset release with memory already ready
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h2002_0001;
        @(posedge clk); #1;
        exp_req = 1'b1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        exp_ir    = 32'h2002_0001;
        exp_valid = 1'b1;
        exp_req   = 1'b0;
        check("first_valid", {31'h0, IR_valid}, 32'h1);
        ack(1'b0, 1'b0);
        check("seq_addr", imem_addr, 32'h4);
        check("seq_count", instr_count, 32'h1);

        // wait states with stray acks while IR is empty
        fetch(32'h0000_0040, 5, 1'b1);
        check("stray_ack_count", instr_count, 32'h1);
        idle_hold(3);
        ack(1'b1, 1'b0);
        check("jump_addr", imem_addr, 32'h0000_0100);

        fetch(32'h1000_FFFF, 0, 1'b0);
        ack(1'b0, 1'b1);
        check("branch_back_addr", imem_addr, 32'h0000_0100);

        fetch(32'h0010_0004, 0, 1'b0);
        ack(1'b1, 1'b0);
        check("jump_far_addr", imem_addr, 32'h0040_0010);

        fetch(32'h0810_0000, 1, 1'b0);
        ack(1'b1, 1'b1);
        check("jump_prio_addr", imem_addr, 32'h0040_0000);

        fetch(32'h0000_0000, 0, 1'b0);
        ack(1'b1, 1'b0);
        check("jump_zero_addr", imem_addr, 32'h0);

        fetch(32'h0000_FFFE, 0, 1'b0);
        ack(1'b0, 1'b1);
        check("branch_neg_addr", imem_addr, 32'hFFFF_FFFC);

        fetch(32'h1234_5678, 2, 1'b1);
        ack(1'b0, 1'b0);
        check("wrap_addr", imem_addr, 32'h0);
        check("count_8", instr_count, 32'd8);

        fetch(32'h0000_0000, 0, 1'b0);
        ack(1'b0, 1'b0);

        // reset in the middle of a fetch, memory answering during reset
        @(posedge clk); #3;
        rst = 1'b1;
        set_reset_expect();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst_async_req", {31'h0, imem_req}, 32'h0);
        check("rst_async_addr", imem_addr, 32'h0);
        check("rst_async_count", instr_count, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_req = 1'b1;
        check("rst_late_ready_ir", IR, 32'h0);
        check("rst_late_ready_valid", {31'h0, IR_valid}, 32'h0);
        imem_ready = 1'b0;
        @(posedge clk); #1;
        fetch(32'h0000_ABCD, 0, 1'b0);
        ack(1'b0, 1'b0);
        check("post_rst_count", instr_count, 32'h1);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
